// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the command master: response codes, the 4 KB rule, FSM states.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4K = 4096;
  localparam int unsigned SPAN_W      = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_RSP
  } mst_state_t;

  // True when a burst starting at this page offset runs past the end of its 4 KB page.
  function automatic logic crosses_4k(input logic [11:0] addr, input logic [7:0] len,
                                      input logic [2:0] size);
    logic [SPAN_W-1:0] off;
    logic [SPAN_W-1:0] bytes;
    off   = SPAN_W'(addr);
    bytes = (SPAN_W'(len) + SPAN_W'(1)) << size;
    return (off + bytes) > SPAN_W'(BOUNDARY_4K);
  endfunction

endpackage

// File: rtl/axi4_cmd_master.sv
// Single-outstanding AXI4 burst master: command/stream front end to AW/W/B or AR/R traffic.
// Illegal bursts (size > 4 bytes or crossing 4 KB) are answered locally with SLVERR.
module axi4_cmd_master
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_proto_err,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  mst_state_t            state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [7:0]            len_q, len_n;
  logic [2:0]            size_q, size_n;
  logic [7:0]            cnt_q, cnt_n;
  logic [1:0]            resp_q, resp_n;
  logic                  perr_q, perr_n;
  logic                  illegal_c;

  assign illegal_c = (cmd_size > 3'd2) || crosses_4k(cmd_addr[11:0], cmd_len, cmd_size);

  // Address/control registers are shared by the AW and AR channels; only the valid differs.
  assign AWADDR        = addr_q;
  assign AWLEN         = len_q;
  assign AWSIZE        = size_q;
  assign ARADDR        = addr_q;
  assign ARLEN         = len_q;
  assign ARSIZE        = size_q;
  assign WDATA         = wr_data;
  assign rd_data       = RDATA;
  assign rsp_resp      = resp_q;
  assign rsp_proto_err = perr_q;

  // State and burst bookkeeping registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      len_q  <= '0;
      size_q <= '0;
      cnt_q  <= '0;
      resp_q <= RESP_OKAY;
      perr_q <= 1'b0;
    end else begin
      state  <= state_n;
      addr_q <= addr_n;
      len_q  <= len_n;
      size_q <= size_n;
      cnt_q  <= cnt_n;
      resp_q <= resp_n;
      perr_q <= perr_n;
    end
  end

  // Next-state, bookkeeping updates and channel handshakes.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    len_n     = len_q;
    size_n    = size_q;
    cnt_n     = cnt_q;
    resp_n    = resp_q;
    perr_n    = perr_q;
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    ARVALID   = 1'b0;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid && !ARESET) begin
          addr_n = cmd_addr;
          len_n  = cmd_len;
          size_n = cmd_size;
          cnt_n  = cmd_len;
          perr_n = 1'b0;
          if (illegal_c) begin
            resp_n  = RESP_SLVERR;
            state_n = ST_RSP;
          end else begin
            resp_n  = RESP_OKAY;
            state_n = cmd_write ? ST_AW : ST_AR;
          end
        end
      end
      ST_AW: begin
        AWVALID = 1'b1;
        if (AWREADY) state_n = ST_W;
      end
      ST_W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = (cnt_q == 8'd0);
        if (wr_valid && WREADY) begin
          if (cnt_q == 8'd0) state_n = ST_B;
          else               cnt_n   = cnt_q - 8'd1;
        end
      end
      ST_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          resp_n  = BRESP;
          state_n = ST_RSP;
        end
      end
      ST_AR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_n = ST_R;
      end
      ST_R: begin
        rd_valid = RVALID;
        rd_last  = RLAST;
        RREADY   = rd_ready;
        if (RVALID && rd_ready) begin
          resp_n = resp_q | RRESP;
          // The beat counter, not RLAST, decides where the burst ends.
          if ((RLAST && cnt_q != 8'd0) || (!RLAST && cnt_q == 8'd0)) perr_n = 1'b1;
          if (cnt_q == 8'd0) state_n = ST_RSP;
          else               cnt_n   = cnt_q - 8'd1;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: doc/axi4_cmd_master.md
# axi4_cmd_master

Single-outstanding AXI4 burst master that sits directly upstream of the memory-mapped AXI4 slave. It converts a simple command/stream interface (one command, a write-data stream, a read-data stream, one completion response) into AW/W/B or AR/R channel traffic. It pre-checks 4 KB boundary and size legality, so illegal bursts never reach the bus.

## Interface
- DATA_WIDTH, 32, data bus width; must be 32 to match the slave.
- ADDR_WIDTH, 16, byte address width.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_len  in  8  beats minus one.
- cmd_size  in  3  log2 bytes per beat.
- wr_data  in  DATA_WIDTH  write beat data.
- wr_valid / wr_ready  in / out  1  write stream handshake.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_valid / rd_ready  out / in  1  read stream handshake.
- rd_last  out  1  final read beat.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_resp  out  2  final response code.
- rsp_proto_err  out  1  RLAST/beat-count disagreement seen; valid with rsp_valid.
- AWADDR, AWLEN, AWSIZE, AWVALID out; AWREADY in. Same for AR*.
- WDATA, WVALID, WLAST out; WREADY in.
- BRESP, BVALID in; BREADY out.
- RDATA, RRESP, RVALID, RLAST in; RREADY out.

## Operation
- States: IDLE, AW, W, B, AR, R, RSP.
- IDLE: cmd_ready=1. On handshake:
  - Latch addr, len, size and reset beat counter to len.
  - Illegal command → RSP with rsp_resp=2'b10. No bus activity.
  - Illegal means cmd_size > 2, or (cmd_addr & 12'hFFF) + ((cmd_len+1) << cmd_size) > 4096. Use ≥17-bit arithmetic. Ending exactly at 4096 is legal.
  - Legal command → AW if cmd_write, otherwise AR.
- AW/AR: AxVALID=1 with registered AxADDR/AxLEN/AxSIZE. Hold stable until AxREADY, then go to W/R.
- W: combinational passthrough.
  - WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY.
  - WLAST=(counter==0).
  - Each WVALID&&WREADY decrements the counter. The handshake at counter 0 goes to B.
- B: BREADY=1. On BVALID, latch BRESP into rsp_resp → RSP.
- R: combinational passthrough.
  - rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST, RREADY=rd_ready.
  - Each beat ORs RRESP into the accumulated response, so the worst code sticks.
  - Set rsp_proto_err on either mismatch: RLAST=1 while counter≠0, or RLAST=0 at counter 0.
  - The beat at counter 0 ends the burst → RSP. The counter governs the end, not RLAST.
- RSP: rsp_valid=1 for exactly one cycle → IDLE. The accumulator and proto flag clear on the next command accept.
- Outside their own states, all channel valid/ready outputs are 0 (cmd_ready excepted in IDLE).
- Reset values:
  - cmd_ready=0 during reset, 1 the first cycle after.
  - All AXI valids, BREADY, RREADY, wr_ready, rd_valid, rsp_valid, rsp_proto_err = 0.
  - AxADDR/AxLEN/AxSIZE = 0; rsp_resp=2'b00; state=IDLE.
- Reset mid-burst: state is abandoned immediately, no rsp_valid, outputs go to reset values.

## Timing
- Command accept to AxVALID: 1 cycle.
- Write data: zero-latency passthrough. A burst of len+1 beats takes len+1 cycles minimum.
- BVALID to rsp_valid: 1 cycle. Final read beat to rsp_valid: 1 cycle.
- Illegal command: rsp_valid 1 cycle after accept.
- Back-to-back: the next cmd_ready is 1 cycle after rsp_valid. Only one transaction is outstanding.
- AxVALID never deasserts before AxREADY. WVALID follows wr_valid; the source must hold it until WREADY.

## Structure
- Shared package axi4_pkg holds:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Constant BOUNDARY_4K=4096.
  - Master state enum.
  - Function crosses_4k(addr, len, size).
- No sub-module: single FSM with counter and accumulator, about 200 lines.

## Test plan
- Write addr 0x0010, len 3, size 2, data 0xA0..0xA3 → one AW, 4 W beats with WLAST on the 4th; BRESP 00 → rsp_resp=00 one cycle after BVALID.
- Read back same addr, len 3 → rd_data 0xA0..0xA3, rd_last on beat 4, rsp_resp=00, rsp_proto_err=0.
- Command addr 0x0FF8, len 3, size 2 (crosses 4 KB) → no AWVALID ever, rsp_valid with rsp_resp=10 one cycle after accept.
- Read len 3 against a stub asserting RLAST on beat 2 → 4 beats still consumed, rsp_proto_err=1. Stub RRESP=10 on beat 3 → rsp_resp=10.
- AWREADY held low 5 cycles and rd_ready toggled → AWADDR/AWLEN stable throughout, no beat lost or duplicated.
- ARESET asserted mid write burst (beat 2 of 4) → all valids 0 immediately, no rsp_valid, cmd_ready=1 the cycle after release.
